// File: rtl/argon_pkg.sv
// Shared definitions for the Argon control unit: opcodes, instruction fields,
// sequencer states and status-register bit positions.
package argon_pkg;

  localparam logic [3:0] OP_ALUI = 4'hC;
  localparam logic [3:0] OP_LDI  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

  localparam int unsigned ST_ZERO     = 0;
  localparam int unsigned ST_SIGN     = 1;
  localparam int unsigned ST_OVERFLOW = 2;
  localparam int unsigned ST_CARRY    = 3;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    FETCH_IMM,
    EXECUTE,
    HALTED
  } state_e;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] alu_op;
    logic       needs_imm;
    logic       is_write;
    logic       is_alu;
    logic       is_halt;
  } decode_t;

endpackage

// File: rtl/argon_decoder.sv
// Combinational instruction decoder: splits the IR into register fields and
// classifies the opcode for the sequencer.
module argon_decoder
  import argon_pkg::*;
#(
  parameter logic [3:0] ALU_OP_LAST = 4'hB
) (
  input  logic [15:0] ir_i,
  output decode_t     dec_o
);

  logic [3:0] opc;

  always_comb begin
    opc          = ir_i[OPC_MSB:OPC_LSB];
    dec_o        = '0;
    dec_o.rd     = ir_i[RD_MSB:RD_LSB];
    dec_o.rs1    = ir_i[RS1_MSB:RS1_LSB];
    dec_o.rs2    = ir_i[RS2_MSB:RS2_LSB];
    if (opc <= ALU_OP_LAST) begin
      dec_o.alu_op   = opc;
      dec_o.is_write = 1'b1;
      dec_o.is_alu   = 1'b1;
    end else begin
      // Opcodes above ALU_OP_LAST that are not named below decode as NOP.
      case (opc)
        OP_ALUI: begin
          dec_o.alu_op    = ir_i[RS2_MSB:RS2_LSB];
          dec_o.needs_imm = 1'b1;
          dec_o.is_write  = 1'b1;
          dec_o.is_alu    = 1'b1;
        end
        OP_LDI: begin
          dec_o.needs_imm = 1'b1;
          dec_o.is_write  = 1'b1;
        end
        OP_HALT: dec_o.is_halt = 1'b1;
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/argon_control_unit.sv
// Argon instruction sequencer: fetches over req/valid, decodes, and issues one
// registered datapath operation per instruction; latches ALU flags.
module argon_control_unit
  import argon_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  ALU_OP_LAST = 4'hB
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  output logic        o_fetch_req,
  output logic [15:0] o_fetch_addr,
  input  logic        i_fetch_valid,
  input  logic [15:0] i_fetch_data,
  output logic [3:0]  o_selectA,
  output logic [3:0]  o_selectB,
  output logic [3:0]  o_selectW,
  output logic        o_write_en,
  output logic [3:0]  o_alu_op,
  output logic        o_use_immediate,
  output logic        o_write_to_regfile,
  output logic [15:0] o_immediate,
  input  logic        i_flag_zero,
  input  logic        i_flag_sign,
  input  logic        i_flag_overflow,
  input  logic        i_flag_carry,
  output logic [3:0]  o_status,
  output logic        o_halted
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] imm_q, imm_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  sel_a_q, sel_a_d;
  logic [3:0]  sel_b_q, sel_b_d;
  logic [3:0]  sel_w_q, sel_w_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        use_imm_q, use_imm_d;
  logic        wtr_q, wtr_d;
  logic [3:0]  status_q, status_d;
  logic        halted_q, halted_d;
  logic        accept;
  logic        load_ctrl;
  decode_t     dec;

  argon_decoder #(
    .ALU_OP_LAST(ALU_OP_LAST)
  ) u_decoder (
    .ir_i (ir_q),
    .dec_o(dec)
  );

  assign accept = req_q & i_fetch_valid;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    sel_w_d   = sel_w_q;
    alu_op_d  = alu_op_q;
    use_imm_d = use_imm_q;
    wtr_d     = wtr_q;
    status_d  = status_q;
    we_d      = 1'b0;
    load_ctrl = 1'b0;

    case (state_q)
      FETCH: begin
        if (accept) begin
          ir_d    = i_fetch_data;
          pc_d    = pc_q + 16'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec.needs_imm) begin
          state_d = FETCH_IMM;
        end else begin
          state_d   = EXECUTE;
          load_ctrl = 1'b1;
        end
      end
      FETCH_IMM: begin
        if (accept) begin
          imm_d     = i_fetch_data;
          pc_d      = pc_q + 16'd1;
          state_d   = EXECUTE;
          load_ctrl = 1'b1;
        end
      end
      EXECUTE: begin
        if (dec.is_alu) begin
          status_d[ST_ZERO]     = i_flag_zero;
          status_d[ST_SIGN]     = i_flag_sign;
          status_d[ST_OVERFLOW] = i_flag_overflow;
          status_d[ST_CARRY]    = i_flag_carry;
        end
        state_d = dec.is_halt ? HALTED : FETCH;
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase

    // Control outputs are loaded on the edge into EXECUTE so they are
    // already valid during the EXECUTE cycle.
    if (load_ctrl) begin
      sel_a_d   = dec.rs1;
      sel_b_d   = dec.rs2;
      sel_w_d   = dec.rd;
      alu_op_d  = dec.alu_op;
      use_imm_d = dec.needs_imm & dec.is_alu;
      wtr_d     = dec.needs_imm & ~dec.is_alu;
      we_d      = dec.is_write;
    end

    req_d    = (state_d == FETCH) || (state_d == FETCH_IMM);
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      imm_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      sel_w_q   <= '0;
      alu_op_q  <= '0;
      use_imm_q <= 1'b0;
      wtr_q     <= 1'b0;
      status_q  <= '0;
      halted_q  <= 1'b0;
    end else if (!i_halt) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      sel_w_q   <= sel_w_d;
      alu_op_q  <= alu_op_d;
      use_imm_q <= use_imm_d;
      wtr_q     <= wtr_d;
      status_q  <= status_d;
      halted_q  <= halted_d;
    end
  end

  assign o_fetch_req        = req_q;
  assign o_fetch_addr       = pc_q;
  assign o_selectA          = sel_a_q;
  assign o_selectB          = sel_b_q;
  assign o_selectW          = sel_w_q;
  assign o_write_en         = we_q;
  assign o_alu_op           = alu_op_q;
  assign o_use_immediate    = use_imm_q;
  assign o_write_to_regfile = wtr_q;
  assign o_immediate        = imm_q;
  assign o_status           = status_q;
  assign o_halted           = halted_q;

endmodule

// File: tb/tb_argon_control_unit.sv
// Scoreboard bench for argon_control_unit: directed programs push expected
// fetch addresses and write records; a monitor pops and compares them.
module tb_argon_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, halt, fz, fs, fo, fc;
  logic        req, valid, we, ui, wtr, halted;
  logic [15:0] addr, data, imm;
  logic [3:0]  selA, selB, selW, alu_op, status;
  logic        req2, valid2, we2, ui2, wtr2, halted2;
  logic [15:0] addr2, data2, imm2;
  logic [3:0]  selA2, selB2, selW2, alu2, status2;

  logic [15:0] mem [0:65535];
  int unsigned mem_wait = 0;
  int unsigned cnt = 0;
  logic        spur = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [3:0]  a, b, w, op;
    logic        ui, wtr;
    logic [15:0] imm;
    logic        chk_alu, chk_b, chk_imm;
  } wr_t;

  logic [15:0] exp_fetch [$];
  wr_t         exp_wr [$];

  always #5 clk = ~clk;

  // Instruction memory with programmable wait states and optional spurious valid while req=0
  always @(posedge clk) begin
    if (!req) cnt <= mem_wait;
    else if (cnt != 0) cnt <= cnt - 1;
  end
  assign valid  = rst_n & ((req & (cnt == 0)) | (~req & spur));
  assign data   = mem[addr];
  assign valid2 = req2;
  assign data2  = (addr2 == 16'h0000) ? 16'hF000 : 16'hE000;

  argon_control_unit dut (
    .i_clk(clk), .i_reset(rst_n), .i_halt(halt),
    .o_fetch_req(req), .o_fetch_addr(addr), .i_fetch_valid(valid), .i_fetch_data(data),
    .o_selectA(selA), .o_selectB(selB), .o_selectW(selW), .o_write_en(we),
    .o_alu_op(alu_op), .o_use_immediate(ui), .o_write_to_regfile(wtr), .o_immediate(imm),
    .i_flag_zero(fz), .i_flag_sign(fs), .i_flag_overflow(fo), .i_flag_carry(fc),
    .o_status(status), .o_halted(halted)
  );

  argon_control_unit #(.RESET_PC(16'hFFFF)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_halt(halt),
    .o_fetch_req(req2), .o_fetch_addr(addr2), .i_fetch_valid(valid2), .i_fetch_data(data2),
    .o_selectA(selA2), .o_selectB(selB2), .o_selectW(selW2), .o_write_en(we2),
    .o_alu_op(alu2), .o_use_immediate(ui2), .o_write_to_regfile(wtr2), .o_immediate(imm2),
    .i_flag_zero(fz), .i_flag_sign(fs), .i_flag_overflow(fo), .i_flag_carry(fc),
    .o_status(status2), .o_halted(halted2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [3:0] a, b, w, op, input logic ui_, wtr_,
                             input logic [15:0] im, input logic ca, cb, ci);
    wr_t r;
    r.a = a; r.b = b; r.w = w; r.op = op; r.ui = ui_; r.wtr = wtr_; r.imm = im;
    r.chk_alu = ca; r.chk_b = cb; r.chk_imm = ci;
    return r;
  endfunction

  // Monitor: samples 1 time unit after the falling edge, i.e. the values the next rising edge sees
  logic we_prev = 1'b0;
  always begin
    wr_t e;
    @(negedge clk);
    #1;
    if (rst_n && req && valid && !halt) begin
      if (exp_fetch.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch_extra: got addr 0x%0h expected no fetch", addr);
      end else begin
        chk("fetch_addr", {16'h0, addr}, {16'h0, exp_fetch.pop_front()});
      end
    end
    if (we && !we_prev) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_extra: got write to r%0d expected no write", selW);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_selW", {28'h0, selW}, {28'h0, e.w});
        chk("wr_to_regfile", {31'h0, wtr}, {31'h0, e.wtr});
        if (e.chk_alu) begin
          chk("wr_selA", {28'h0, selA}, {28'h0, e.a});
          chk("wr_alu_op", {28'h0, alu_op}, {28'h0, e.op});
          chk("wr_use_imm", {31'h0, ui}, {31'h0, e.ui});
        end
        if (e.chk_b) chk("wr_selB", {28'h0, selB}, {28'h0, e.b});
        if (e.chk_imm) chk("wr_immediate", {16'h0, imm}, {16'h0, e.imm});
      end
    end
    we_prev = we;
  end

  task automatic start_reset();
    @(negedge clk);
    rst_n = 1'b0; halt = 1'b0; spur = 1'b0; mem_wait = 0;
    repeat (2) @(negedge clk);
    exp_fetch.delete();
    exp_wr.delete();
    for (int i = 0; i < 16; i++) mem[i] = 16'hE000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_req"}, {31'h0, req}, 32'h0);
    chk({nm, "_addr"}, {16'h0, addr}, 32'h0);
    chk({nm, "_we"}, {31'h0, we}, 32'h0);
    chk({nm, "_sel"}, {20'h0, selA, selB, selW}, 32'h0);
    chk({nm, "_alu_op"}, {28'h0, alu_op}, 32'h0);
    chk({nm, "_muxes"}, {30'h0, ui, wtr}, 32'h0);
    chk({nm, "_imm"}, {16'h0, imm}, 32'h0);
    chk({nm, "_status"}, {28'h0, status}, 32'h0);
    chk({nm, "_halted"}, {31'h0, halted}, 32'h0);
  endtask

  task automatic wait_halted(input string nm);
    int n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_halted"}, {31'h0, halted}, 32'h1);
    chk({nm, "_req_off"}, {31'h0, req}, 32'h0);
    chk({nm, "_fetch_left"}, exp_fetch.size(), 32'h0);
    chk({nm, "_write_left"}, exp_wr.size(), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic found;
    rst_n = 1'b0; halt = 1'b0; fz = 1'b0; fs = 1'b0; fo = 1'b0; fc = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hE000;

    // Reg-reg ALU, zero-wait, 3-cycle latency
    start_reset();
    mem[0] = 16'h3123; mem[1] = 16'hF000; fs = 1'b1;
    reset_checks("t1_reset");
    exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
    exp_wr.push_back(mk(4'd2, 4'd3, 4'd1, 4'd3, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
    release_reset();
    @(negedge clk); chk("t1_c1_req", {31'h0, req}, 32'h1); chk("t1_c1_addr", {16'h0, addr}, 32'h0);
    @(negedge clk); chk("t1_c2_we", {31'h0, we}, 32'h0);
    @(negedge clk); chk("t1_c3_we", {31'h0, we}, 32'h1);
    @(negedge clk); chk("t1_c4_we", {31'h0, we}, 32'h0);
    chk("t1_c4_req", {31'h0, req}, 32'h1); chk("t1_c4_addr", {16'h0, addr}, 32'h1);
    wait_halted("t1");
    chk("t1_status", {28'h0, status}, 32'h2);

    // LDI: flags must not be latched
    start_reset();
    mem[0] = 16'hD500; mem[1] = 16'hBEEF; mem[2] = 16'hF000;
    fz = 1'b1; fs = 1'b1; fo = 1'b1; fc = 1'b1;
    exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001); exp_fetch.push_back(16'h0002);
    exp_wr.push_back(mk(4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1));
    release_reset();
    wait_halted("t2");
    chk("t2_status", {28'h0, status}, 32'h0);

    // ALUI, then reg-reg including opcode ALU_OP_LAST
    start_reset();
    mem[0] = 16'hC712; mem[1] = 16'h0001; mem[2] = 16'h0A45; mem[3] = 16'hB321; mem[4] = 16'hF000;
    fz = 1'b1; fs = 1'b0; fo = 1'b0; fc = 1'b1;
    for (int i = 0; i < 5; i++) exp_fetch.push_back(16'(i));
    exp_wr.push_back(mk(4'd1, 4'd0, 4'd7, 4'd2, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1));
    exp_wr.push_back(mk(4'd4, 4'd5, 4'hA, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
    exp_wr.push_back(mk(4'd2, 4'd1, 4'd3, 4'hB, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
    release_reset();
    wait_halted("t3");
    chk("t3_status", {28'h0, status}, 32'h9);

    // Wait states plus spurious valid while req is low
    start_reset();
    mem[0] = 16'h5678; mem[1] = 16'hE000; mem[2] = 16'hF000;
    fz = 1'b0; fs = 1'b0; fo = 1'b1; fc = 1'b0;
    mem_wait = 3; spur = 1'b1;
    exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001); exp_fetch.push_back(16'h0002);
    exp_wr.push_back(mk(4'd7, 4'd8, 4'd6, 4'd5, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
    release_reset();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req) n++;
      if (req && valid) break;
    end
    chk("t4_req_cycles", n, 32'd4);
    @(negedge clk); chk("t4_decode_addr", {16'h0, addr}, 32'h1); chk("t4_decode_req", {31'h0, req}, 32'h0);
    @(negedge clk); chk("t4_exec_we", {31'h0, we}, 32'h1); chk("t4_exec_addr", {16'h0, addr}, 32'h1);
    wait_halted("t4");
    chk("t4_status", {28'h0, status}, 32'h4);

    // Stall inside FETCH_IMM, then reset while still stalled
    start_reset();
    mem[0] = 16'h3123; mem[1] = 16'hC712; mem[2] = 16'h0001; mem[3] = 16'hF000;
    fz = 1'b1; fs = 1'b0; fo = 1'b0; fc = 1'b0;
    exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
    exp_wr.push_back(mk(4'd2, 4'd3, 4'd1, 4'd3, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
    release_reset();
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req && addr == 16'h0002) begin found = 1'b1; break; end
    end
    chk("t5_reach_fetch_imm", {31'h0, found}, 32'h1);
    halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_req", {31'h0, req}, 32'h1);
      chk("t5_stall_addr", {16'h0, addr}, 32'h2);
      chk("t5_stall_we", {31'h0, we}, 32'h0);
      chk("t5_stall_selW", {28'h0, selW}, 32'h1);
      chk("t5_stall_status", {28'h0, status}, 32'h1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("t5_reset");
    chk("t5_fetch_left", exp_fetch.size(), 32'h0);
    chk("t5_write_left", exp_wr.size(), 32'h0);
    halt = 1'b0;

    // PC wrap from RESET_PC=0xFFFF, NOP then HALT (second instance)
    start_reset();
    mem[0] = 16'hF000;
    exp_fetch.push_back(16'h0000);
    release_reset();
    @(negedge clk); chk("t6_c1_req", {31'h0, req2}, 32'h1); chk("t6_c1_addr", {16'h0, addr2}, 32'hFFFF);
    @(negedge clk); chk("t6_c2_we", {31'h0, we2}, 32'h0);
    @(negedge clk); chk("t6_c3_we", {31'h0, we2}, 32'h0);
    @(negedge clk); chk("t6_c4_req", {31'h0, req2}, 32'h1); chk("t6_c4_addr", {16'h0, addr2}, 32'h0);
    @(negedge clk); chk("t6_c5_we", {31'h0, we2}, 32'h0);
    @(negedge clk); chk("t6_c6_we", {31'h0, we2}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_halted", {31'h0, halted2}, 32'h1);
      chk("t6_req_off", {31'h0, req2}, 32'h0);
      chk("t6_no_write", {31'h0, we2}, 32'h0);
    end
    wait_halted("t6_dut1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
